// File: rtl/console_pkg.sv
// console_pkg: definitions shared by the console input and output ports.
//   - register offsets within the 8-byte console window
//   - STATUS bit positions and the DATA valid bit
//   - register-select enum and its decode helper
package console_pkg;

  localparam logic [2:0] OFF_DATA   = 3'd0;
  localparam logic [2:0] OFF_STATUS = 3'd4;

  localparam int unsigned ST_NEMPTY    = 0;
  localparam int unsigned ST_FULL      = 1;
  localparam int unsigned ST_OVF       = 2;
  localparam int unsigned ST_IRQEN     = 3;
  localparam int unsigned ST_CNT_LSB   = 8;
  localparam int unsigned DATA_VLD_BIT = 31;

  typedef enum logic {
    RegData   = 1'b0,
    RegStatus = 1'b1
  } reg_sel_e;

  // The window is 8-byte aligned, so address bit 2 alone separates DATA from STATUS.
  function automatic reg_sel_e decode_reg(input logic [2:0] off);
    return (off[2] == OFF_STATUS[2]) ? RegStatus : RegData;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: synchronous byte FIFO with a registered occupancy count.
//   clk, resetn : clock, synchronous active-low reset
//   push, din   : enqueue din (ignored when full unless popping in the same cycle)
//   pop         : dequeue head (ignored when empty)
//   dout        : current head byte (meaningless while empty)
//   full, empty : occupancy flags
//   count       : number of stored bytes, 0..DEPTH
module byte_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [7:0]       din,
  input  logic             pop,
  output logic [7:0]       dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [7:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd;
  logic [PTR_W-1:0] r_wr;
  logic [CNT_W-1:0] r_count;

  logic w_pop;
  logic w_push;

  assign w_pop  = pop & (r_count != '0);
  // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
  assign w_push = push & ((r_count != CNT_W'(DEPTH)) | w_pop);

  // Storage carries no reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  assign dout  = r_mem[r_rd];
  assign full  = (r_count == CNT_W'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;

endmodule

// File: rtl/console_in_mmio.sv
// console_in_mmio: memory-mapped console input port on the PicoRV32 native bus.
// Host bytes strobed on in_byte/in_byte_en are queued; the CPU reads them through
// DATA (BASE_ADDR) and checks state through STATUS (BASE_ADDR+4).
//   clk, resetn            : clock, synchronous active-low reset
//   in_byte, in_byte_en    : host byte and 1-cycle push strobe (no backpressure)
//   mem_valid, mem_addr    : CPU request and byte address
//   mem_wdata, mem_wstrb   : write data and strobes (wstrb==0 means read)
//   mem_ready, mem_rdata   : 1-cycle acknowledge and read data (0 when not ready)
//   irq                    : registered level, FIFO non-empty AND irq_en
module console_in_mmio
  import console_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0010,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned CNT_W     = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  in_byte,
  input  logic        in_byte_en,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        irq
);

  logic             w_hit;
  logic             w_is_write;
  reg_sel_e         w_sel;
  logic [7:0]       w_head;
  logic             w_full;
  logic             w_empty;
  logic [CNT_W-1:0] w_count;
  logic             w_pop;
  logic             w_ovf_set;
  logic [31:0]      w_status;
  logic [31:0]      w_rd_val;
  logic             w_unused;

  logic        r_ready;
  logic [31:0] r_rdata;
  logic        r_pop_pend;
  logic        r_ovf;
  logic        r_irq_en;
  logic        r_irq;

  // !mem_ready keeps a still-held mem_valid from being accepted twice.
  assign w_hit      = mem_valid & ~r_ready & (mem_addr[31:3] == BASE_ADDR[31:3]);
  assign w_is_write = (mem_wstrb != 4'b0000);
  assign w_sel      = decode_reg(mem_addr[2:0]);

  // The head is captured into rdata at the accept edge and popped at the edge that
  // ends the ready cycle; no new accept can happen in between.
  assign w_pop      = r_ready & r_pop_pend;
  assign w_ovf_set  = in_byte_en & w_full & ~w_pop;

  byte_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (in_byte_en),
    .din    (in_byte),
    .pop    (w_pop),
    .dout   (w_head),
    .full   (w_full),
    .empty  (w_empty),
    .count  (w_count)
  );

  always_comb begin
    w_status                         = '0;
    w_status[ST_NEMPTY]              = ~w_empty;
    w_status[ST_FULL]                = w_full;
    w_status[ST_OVF]                 = r_ovf;
    w_status[ST_IRQEN]               = r_irq_en;
    w_status[ST_CNT_LSB +: CNT_W]    = w_count;
  end

  always_comb begin
    w_rd_val = '0;
    if (w_sel == RegStatus) begin
      w_rd_val = w_status;
    end else if (!w_empty) begin
      w_rd_val               = {24'h0, w_head};
      w_rd_val[DATA_VLD_BIT] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_ready    <= 1'b0;
      r_rdata    <= '0;
      r_pop_pend <= 1'b0;
      r_ovf      <= 1'b0;
      r_irq_en   <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      r_ready    <= w_hit;
      r_rdata    <= (w_hit && !w_is_write) ? w_rd_val : 32'h0;
      r_pop_pend <= w_hit & ~w_is_write & (w_sel == RegData) & ~w_empty;
      if (w_hit && w_is_write && (w_sel == RegStatus) && mem_wstrb[0]) begin
        r_irq_en <= mem_wdata[ST_IRQEN];
        if (mem_wdata[ST_OVF]) r_ovf <= 1'b0;
      end
      // Placed after the clear so a simultaneous overflow wins.
      if (w_ovf_set) r_ovf <= 1'b1;
      r_irq <= ~w_empty & r_irq_en;
    end
  end

  assign mem_ready = r_ready;
  assign mem_rdata = r_rdata;
  assign irq       = r_irq;

  assign w_unused = ^{mem_wdata[31:4], mem_wdata[1:0], mem_wstrb[3:1], mem_addr[1:0]};

endmodule

// File: tb/tb_console_in_mmio.sv
module tb_console_in_mmio;

  localparam logic [31:0] BASE = 32'h1000_0010;
  localparam logic [31:0] STAT = 32'h1000_0014;
  localparam int          DEP  = 8;

  logic        clk = 1'b0;
  logic        resetn;
  logic [7:0]  in_byte;
  logic        in_byte_en;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        irq;

  console_in_mmio dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_byte    (in_byte),
    .in_byte_en (in_byte_en),
    .mem_valid  (mem_valid),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: byte queue plus the two control flags.
  logic [7:0] m_q[$];
  logic       m_ovf;
  logic       m_irq_en;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = '0;
    s[0] = (m_q.size() != 0);
    s[1] = (m_q.size() == DEP);
    s[2] = m_ovf;
    s[3] = m_irq_en;
    s[11:8] = 4'(m_q.size());
    return s;
  endfunction

  task automatic m_push(input logic [7:0] b);
    if (m_q.size() < DEP) m_q.push_back(b);
    else m_ovf = 1'b1;
  endtask

  task automatic m_reset();
    m_q.delete();
    m_ovf    = 1'b0;
    m_irq_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after a posedge; returns 1 time unit after a posedge.
  task automatic strobe(input logic [7:0] b);
    in_byte    = b;
    in_byte_en = 1'b1;
    @(posedge clk); #1;
    in_byte_en = 1'b0;
    m_push(b);
  endtask

  // One bus access. push_when: 0 none, 1 host push on the accept edge,
  // 2 host push on the edge that ends the ready cycle.
  task automatic access(input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input int push_when,
                        input logic [7:0] pb, input string tag,
                        output logic [31:0] rd);
    logic        is_stat;
    logic [31:0] exp;
    is_stat   = addr[2];
    mem_valid = 1'b1;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = wstrb;
    if (push_when == 1) begin
      in_byte    = pb;
      in_byte_en = 1'b1;
    end
    exp = 32'h0;
    if (wstrb == 4'b0) begin
      if (is_stat) exp = m_status();
      else if (m_q.size() != 0) exp = {1'b1, 23'h0, m_q[0]};
    end
    @(posedge clk); #1;
    in_byte_en = 1'b0;
    check({tag, "_ready"}, 32'(mem_ready), 32'd1);
    rd = mem_rdata;
    if (wstrb == 4'b0) check({tag, "_rdata"}, mem_rdata, exp);
    mem_valid = 1'b0;
    mem_wstrb = 4'b0;
    if (push_when == 2) begin
      in_byte    = pb;
      in_byte_en = 1'b1;
    end
    // Model: write (clear) before a same-edge push so set wins; pop before an ack-edge push.
    if (is_stat && wstrb[0]) begin
      m_irq_en = wdata[3];
      if (wdata[2]) m_ovf = 1'b0;
    end
    if (push_when == 1) m_push(pb);
    if (wstrb == 4'b0 && !is_stat && m_q.size() != 0) void'(m_q.pop_front());
    if (push_when == 2) m_push(pb);
    @(posedge clk); #1;
    in_byte_en = 1'b0;
    check({tag, "_ready_drop"}, {31'h0, mem_ready}, 32'd0);
  endtask

  logic [31:0] rd;
  logic [31:0] addr;
  int          seen;

  initial begin
    resetn     = 1'b0;
    in_byte    = 8'h00;
    in_byte_en = 1'b0;
    mem_valid  = 1'b0;
    mem_addr   = 32'h0;
    mem_wdata  = 32'h0;
    mem_wstrb  = 4'h0;
    m_reset();
    repeat (3) @(posedge clk);
    // Strobe during reset must be ignored.
    in_byte_en = 1'b1;
    in_byte    = 8'hAA;
    @(posedge clk); #1;
    in_byte_en = 1'b0;
    resetn     = 1'b1;

    // 1. Reset state
    check("rst_ready", {31'h0, mem_ready}, 32'h0);
    check("rst_rdata", mem_rdata, 32'h0);
    check("rst_irq",   {31'h0, irq}, 32'h0);
    access(STAT, 32'h0, 4'h0, 0, 8'h0, "t1_stat", rd);
    check("t1_stat_lit", rd, 32'h0);

    // 2. Two bytes, three DATA reads
    strobe(8'h41);
    strobe(8'h42);
    access(STAT, 32'h0, 4'h0, 0, 8'h0, "t2_stat2", rd);
    check("t2_cnt2", rd, 32'h0000_0201);
    access(BASE, 32'h0, 4'h0, 0, 8'h0, "t2_d0", rd);
    check("t2_d0_lit", rd, 32'h8000_0041);
    access(BASE, 32'h0, 4'h0, 0, 8'h0, "t2_d1", rd);
    check("t2_d1_lit", rd, 32'h8000_0042);
    access(BASE, 32'h0, 4'h0, 0, 8'h0, "t2_d2", rd);
    check("t2_d2_lit", rd, 32'h0);
    access(STAT, 32'h0, 4'h0, 0, 8'h0, "t2_stat0", rd);
    check("t2_cnt0", rd, 32'h0);

    // 3. Overfill with DEPTH+1 bytes
    for (int i = 0; i <= DEP; i++) strobe(8'(i));
    access(STAT, 32'h0, 4'h0, 0, 8'h0, "t3_stat", rd);
    check("t3_stat_lit", rd, 32'h0000_0807);
    for (int i = 0; i < DEP; i++) begin
      access(BASE, 32'h0, 4'h0, 0, 8'h0, "t3_rd", rd);
      check("t3_rd_lit", rd, 32'h8000_0000 | 32'(i));
    end
    access(BASE, 32'h0, 4'h0, 0, 8'h0, "t3_empty", rd);
    check("t3_empty_lit", rd, 32'h0);
    access(STAT, 32'h4, 4'h1, 0, 8'h0, "t3_w1c", rd);

    // 4. Full FIFO, push on the pop edge
    for (int i = 0; i < DEP; i++) strobe(8'h10 + 8'(i));
    access(BASE, 32'h0, 4'h0, 2, 8'h55, "t4_pop", rd);
    check("t4_pop_lit", rd, 32'h8000_0010);
    access(STAT, 32'h0, 4'h0, 0, 8'h0, "t4_stat", rd);
    check("t4_stat_lit", rd, 32'h0000_0803);
    for (int i = 0; i < DEP; i++) access(BASE, 32'h0, 4'h0, 0, 8'h0, "t4_drain", rd);
    check("t4_last", rd, 32'h8000_0055);

    // Overflow set on the same edge as a W1C clear: set wins.
    for (int i = 0; i < DEP; i++) strobe(8'h20 + 8'(i));
    access(STAT, 32'h4, 4'h1, 1, 8'h99, "ovf_race", rd);
    access(STAT, 32'h0, 4'h0, 0, 8'h0, "ovf_race_st", rd);
    check("ovf_race_lit", rd, 32'h0000_0807);
    for (int i = 0; i < DEP; i++) access(BASE, 32'h0, 4'h0, 0, 8'h0, "ovf_drain", rd);

    // 5. irq
    access(STAT, 32'h8, 4'h1, 0, 8'h0, "t5_en", rd);
    strobe(8'h7E);
    seen = 0;
    for (int i = 0; i < 3 && seen == 0; i++) begin
      if (irq) seen = 1;
      else idle(1);
    end
    check("t5_irq_on", 32'(seen), 32'd1);
    access(BASE, 32'h0, 4'h0, 0, 8'h0, "t5_rd", rd);
    check("t5_rd_lit", rd, 32'h8000_007E);
    idle(1);
    check("t5_irq_off", {31'h0, irq}, 32'h0);
    access(STAT, 32'h4, 4'h1, 0, 8'h0, "t5_w1c", rd);
    access(STAT, 32'h0, 4'h0, 0, 8'h0, "t5_stat", rd);
    check("t5_ovf_clr", rd & 32'h4, 32'h0);

    // Address outside the window: no response
    mem_valid = 1'b1;
    mem_addr  = BASE + 32'h8;
    mem_wstrb = 4'h0;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (mem_ready) seen++;
    end
    mem_valid = 1'b0;
    check("miss_noready", 32'(seen), 32'd0);

    // 6. Reset while a request is pending and the FIFO holds data
    strobe(8'h11);
    strobe(8'h22);
    mem_valid = 1'b1;
    mem_addr  = BASE;
    mem_wstrb = 4'h0;
    resetn    = 1'b0;
    @(posedge clk); #1;
    check("t6_noready", {31'h0, mem_ready}, 32'h0);
    resetn    = 1'b1;
    mem_valid = 1'b0;
    m_reset();
    idle(1);
    check("t6_noready2", {31'h0, mem_ready}, 32'h0);
    idle(1);
    check("t6_irq", {31'h0, irq}, 32'h0);
    access(STAT, 32'h0, 4'h0, 0, 8'h0, "t6_stat", rd);
    check("t6_stat_lit", rd, 32'h0);
    access(BASE, 32'h0, 4'h0, 0, 8'h0, "t6_data", rd);
    check("t6_data_lit", rd, 32'h0);

    // Randomised traffic against the model
    for (int it = 0; it < 400; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: strobe(8'($urandom));
        3, 4, 5: access(BASE, 32'h0, 4'h0, int'($urandom_range(0, 2)), 8'($urandom),
                        "r_data", rd);
        6:       access(STAT, 32'h0, 4'h0, int'($urandom_range(0, 2)), 8'($urandom),
                        "r_stat", rd);
        7:       access(STAT, $urandom, 4'($urandom_range(1, 15)), int'($urandom_range(0, 1)),
                        8'($urandom), "r_wr", rd);
        8:       access(BASE, $urandom, 4'($urandom_range(1, 15)), 0, 8'h0, "r_dwr", rd);
        default: begin
          idle(2);
          check("r_irq", {31'h0, irq}, {31'h0, (m_q.size() != 0) && m_irq_en});
        end
      endcase
    end
    access(STAT, 32'h0, 4'h0, 0, 8'h0, "final_stat", rd);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
